// File: rtl/zigzag_rle_encoder.sv
// JPEG run-length symbol generator: converts one zigzag-ordered, quantized 8x8 block
// into a DC difference symbol followed by AC {run,size,amp} symbols with ZRL/EOB.
module zigzag_rle_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int DATA_DEPTH = 8
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0]  in_coeffs,
    input  logic [1:0]                                   in_comp,
    input  logic                                         dc_clear,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [3:0]                                   out_run,
    output logic [3:0]                                   out_size,
    output logic [10:0]                                  out_amp,
    output logic                                         out_is_dc,
    output logic                                         out_last,
    output logic [1:0]                                   out_comp
);
    localparam int NCOEF = DATA_DEPTH * DATA_DEPTH;
    localparam int KW    = $clog2(NCOEF);
    localparam logic [KW-1:0] K_LAST = KW'(NCOEF - 1);
    localparam logic signed [DATA_WIDTH:0] HALF = (DATA_WIDTH+1)'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [DATA_WIDTH:0] QMAX = (DATA_WIDTH+1)'(2047);
    localparam logic signed [DATA_WIDTH:0] QMIN = -QMAX;

    typedef logic signed [11:0] qval_t;
    typedef enum logic [1:0] {S_IDLE, S_DC, S_AC, S_DONE} state_t;
    typedef struct packed {
        logic [3:0]  run;
        logic [3:0]  size;
        logic [10:0] amp;
    } sym_t;

    // Round to nearest (half up) and clamp to the 11-bit magnitude JPEG range.
    function automatic qval_t to_int(input logic [DATA_WIDTH-1:0] c);
        logic signed [DATA_WIDTH:0] s;
        s = ($signed({c[DATA_WIDTH-1], c}) + HALF) >>> FRAC_BITS;
        if (s > QMAX) return 12'sd2047;
        if (s < QMIN) return -12'sd2047;
        return s[11:0];
    endfunction

    function automatic logic [3:0] size_of(input qval_t v);
        logic [11:0] mag;
        logic [3:0]  sz;
        mag = v[11] ? 12'(-v) : v;
        sz  = '0;
        for (int i = 0; i < 11; i++)
            if (mag[i]) sz = 4'(i + 1);
        return sz;
    endfunction

    function automatic logic [10:0] amp_of(input qval_t v);
        qval_t       t;
        logic [10:0] mask;
        t    = v - 12'sd1;
        mask = 11'((12'd1 << size_of(v)) - 12'd1);
        return v[11] ? (t[10:0] & mask) : v[10:0];
    endfunction

    state_t                             state;
    logic [NCOEF-1:0][DATA_WIDTH-1:0]   coef;
    logic [1:0]                         comp;
    qval_t                              dc_q;
    logic [2:0][11:0]                   pred;
    logic [KW-1:0]                      k;
    logic [KW-1:0]                      run;

    logic [1:0]          comp_in;
    qval_t               q_in0;
    qval_t               q_k;
    qval_t               dc_diff;
    logic signed [12:0]  diff_w;

    assign in_ready = (state == S_IDLE) && !reset;
    assign comp_in  = (in_comp == 2'd3) ? 2'd0 : in_comp;
    assign q_in0    = to_int(in_coeffs[DATA_WIDTH-1:0]);
    assign q_k      = to_int(coef[k]);
    assign diff_w   = $signed({q_in0[11], q_in0}) - $signed({pred[comp_in][11], pred[comp_in]});
    assign dc_diff  = (diff_w > 13'sd2047)  ? 12'sd2047 :
                      (diff_w < -13'sd2047) ? -12'sd2047 : diff_w[11:0];

    // Decision for the coefficient currently addressed by k.
    logic ac_emit, ac_last, ac_zrl;
    sym_t ac_sym;
    always_comb begin
        ac_emit = 1'b0;
        ac_last = 1'b0;
        ac_zrl  = 1'b0;
        ac_sym  = '0;
        if (q_k == 12'sd0) begin
            if (k == K_LAST) begin
                ac_emit = 1'b1;
                ac_last = 1'b1;
            end
        end else if (run >= KW'(16)) begin
            ac_emit = 1'b1;
            ac_zrl  = 1'b1;
            ac_sym  = '{run: 4'd15, size: 4'd0, amp: 11'd0};
        end else begin
            ac_emit = 1'b1;
            ac_last = (k == K_LAST);
            ac_sym  = '{run: run[3:0], size: size_of(q_k), amp: amp_of(q_k)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            coef      <= '0;
            comp      <= '0;
            dc_q      <= '0;
            pred      <= '0;
            k         <= '0;
            run       <= '0;
            out_valid <= 1'b0;
            out_run   <= '0;
            out_size  <= '0;
            out_amp   <= '0;
            out_is_dc <= 1'b0;
            out_last  <= 1'b0;
            out_comp  <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    coef      <= in_coeffs;
                    comp      <= comp_in;
                    dc_q      <= q_in0;
                    out_valid <= 1'b1;
                    out_run   <= '0;
                    out_size  <= size_of(dc_diff);
                    out_amp   <= amp_of(dc_diff);
                    out_is_dc <= 1'b1;
                    out_last  <= 1'b0;
                    out_comp  <= comp_in;
                    state     <= S_DC;
                end
                S_DC: if (out_ready) begin
                    pred[comp] <= dc_q;
                    k          <= KW'(1);
                    run        <= '0;
                    out_valid  <= 1'b0;
                    out_is_dc  <= 1'b0;
                    state      <= S_AC;
                end
                // A handshake and the next evaluation may share a cycle.
                S_AC: if (!out_valid || out_ready) begin
                    out_valid                     <= ac_emit;
                    {out_run, out_size, out_amp}  <= ac_sym;
                    out_last                      <= ac_last;
                    if (!ac_emit) begin
                        run <= run + KW'(1);
                        k   <= k + KW'(1);
                    end else if (ac_zrl) begin
                        run <= run - KW'(16);
                    end else begin
                        run <= '0;
                        k   <= k + KW'(1);
                    end
                    if (ac_last) state <= S_DONE;
                end
                S_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // Restart marker takes priority over a coincident predictor update.
            if (dc_clear) pred <= '0;
        end
    end
endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// Bench for zigzag_rle_encoder: symbol-list model per block, handshake monitor, directed pins.
module tb_zigzag_rle_encoder;
    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [63:0][31:0] coefs;
    logic [1:0]        in_comp;
    logic              dc_clear;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_run;
    logic [3:0]        out_size;
    logic [10:0]       out_amp;
    logic              out_is_dc;
    logic              out_last;
    logic [1:0]        out_comp;

    zigzag_rle_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_coeffs(coefs), .in_comp(in_comp), .dc_clear(dc_clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_run(out_run),
        .out_size(out_size), .out_amp(out_amp), .out_is_dc(out_is_dc),
        .out_last(out_last), .out_comp(out_comp)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [22:0] exp_q[$];
    int          pred_m[3];
    bit          stall_mode = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp_v);
    endtask

    function automatic logic [22:0] sym(int run, int size, int amp, int dc, int last, int comp);
        return {1'(dc), 1'(last), 2'(comp), 4'(run), 4'(size), 11'(amp)};
    endfunction

    function automatic int qint(input logic [31:0] c);
        int v;
        v = $rtoi($floor(($itor($signed(c)) + 32768.0) / 65536.0));
        if (v > 2047) v = 2047;
        if (v < -2047) v = -2047;
        return v;
    endfunction

    function automatic int jsize(int v);
        int a = (v < 0) ? -v : v;
        int s = 0;
        while ((1 << s) <= a) s++;
        return s;
    endfunction

    function automatic int jamp(int v);
        return (v >= 0) ? v : v + (1 << jsize(v)) - 1;
    endfunction

    // Expected symbol list for one block, straight from the JPEG run-length rules.
    task automatic model_block(input logic [63:0][31:0] c, input int comp_raw);
        int comp, d, run;
        int q[64];
        comp = (comp_raw == 3) ? 0 : comp_raw;
        for (int i = 0; i < 64; i++) q[i] = qint(c[i]);
        d = q[0] - pred_m[comp];
        if (d > 2047) d = 2047;
        if (d < -2047) d = -2047;
        exp_q.push_back(sym(0, jsize(d), jamp(d), 1, 0, comp));
        pred_m[comp] = q[0];
        run = 0;
        for (int i = 1; i < 64; i++) begin
            if (q[i] == 0) begin
                if (i == 63) exp_q.push_back(sym(0, 0, 0, 0, 1, comp));
                else run++;
            end else begin
                while (run >= 16) begin
                    exp_q.push_back(sym(15, 0, 0, 0, 0, comp));
                    run -= 16;
                end
                exp_q.push_back(sym(run, jsize(q[i]), jamp(q[i]), 0, (i == 63) ? 1 : 0, comp));
                run = 0;
            end
        end
    endtask

    task automatic drive_block(input logic [63:0][31:0] c, input int comp);
        int n = 0;
        while (!in_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        coefs    = c;
        in_comp  = 2'(comp);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("first_sym_latency", {out_valid, in_ready}, 64'b10);
    endtask

    task automatic send_block(input logic [63:0][31:0] c, input int comp);
        model_block(c, comp);
        drive_block(c, comp);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_idle", {exp_q.size() == 0, in_ready}, 64'b11);
    endtask

    task automatic pulse_clear();
        drain();
        dc_clear = 1'b1;
        @(posedge clk); #1;
        dc_clear = 1'b0;
        for (int i = 0; i < 3; i++) pred_m[i] = 0;
    endtask

    task automatic pin(input string nm, input int idx, input logic [22:0] e);
        chk(nm, 64'(exp_q[idx]), 64'(e));
    endtask

    // out_ready driver: always ready in directed phases, ~30% low in the random phase.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = stall_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Compare process: every handshake against the model, and stability across stalls.
    logic [22:0] prev_sym;
    bit          prev_stall = 1'b0;
    always @(negedge clk) begin
        logic [22:0] cur;
        logic [22:0] e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            cur = {out_is_dc, out_last, out_comp, out_run, out_size, out_amp};
            if (prev_stall) chk("stall_hold", {out_valid, cur}, {1'b1, prev_sym});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_symbol", 64'(exp_q.size()), 64'd1);
                else begin
                    e = exp_q.pop_front();
                    chk("symbol", 64'(cur), 64'(e));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_sym   = cur;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0][31:0] blk;
        int r, m;
        reset = 1'b1; in_valid = 1'b0; dc_clear = 1'b0; coefs = '0; in_comp = '0;
        for (int i = 0; i < 3; i++) pred_m[i] = 0;
        #12;
        chk("reset_outputs", {out_valid, in_ready, out_run, out_size, out_amp,
                              out_is_dc, out_last, out_comp}, 64'd0);
        @(posedge clk); #3 reset = 1'b0;
        #1 chk("ready_after_release", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Reset in the middle of an AC scan abandons the block.
        blk = '0; blk[0] = 32'(3 <<< 16); blk[30] = 32'(5 <<< 16);
        model_block(blk, 1);
        drive_block(blk, 1);
        repeat (6) @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("midscan_reset_outputs", {out_valid, in_ready, out_run, out_size, out_amp,
                                         out_is_dc, out_last, out_comp}, 64'd0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) pred_m[i] = 0;
        @(posedge clk); #3 reset = 1'b0;
        #1 chk("ready_after_midscan_reset", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        model_block(blk, 1);
        pin("post_reset_dc", 0, sym(0, 2, 3, 1, 0, 1));
        drive_block(blk, 1);
        drain();

        // All-zero Y block, twice.
        pulse_clear();
        blk = '0;
        for (int t = 0; t < 2; t++) begin
            model_block(blk, 0);
            chk("zero_blk_len", 64'(exp_q.size()), 64'd2);
            pin("zero_blk_dc", 0, sym(0, 0, 0, 1, 0, 0));
            pin("zero_blk_eob", 1, sym(0, 0, 0, 0, 1, 0));
            drive_block(blk, 0);
            drain();
        end

        // q0=5, q1=-3, q20=1.
        blk = '0; blk[0] = 32'(5 <<< 16); blk[1] = 32'(-3 <<< 16); blk[20] = 32'(1 <<< 16);
        model_block(blk, 0);
        pin("t3_dc",  0, sym(0, 3, 5, 1, 0, 0));
        pin("t3_ac1", 1, sym(0, 2, 0, 0, 0, 0));
        pin("t3_zrl", 2, sym(15, 0, 0, 0, 0, 0));
        pin("t3_ac2", 3, sym(2, 1, 1, 0, 0, 0));
        pin("t3_eob", 4, sym(0, 0, 0, 0, 1, 0));
        drive_block(blk, 0);
        drain();

        // DC predictors per component and dc_clear.
        pulse_clear();
        blk = '0; blk[0] = 32'(10 <<< 16);
        model_block(blk, 0); pin("dc_y10", 0, sym(0, 4, 10, 1, 0, 0)); drive_block(blk, 0); drain();
        blk[0] = 32'(4 <<< 16);
        model_block(blk, 1); pin("dc_cb4", 0, sym(0, 3, 4, 1, 0, 1)); drive_block(blk, 1); drain();
        blk[0] = 32'(7 <<< 16);
        model_block(blk, 0); pin("dc_y7", 0, sym(0, 2, 0, 1, 0, 0)); drive_block(blk, 0); drain();
        pulse_clear();
        model_block(blk, 0); pin("dc_clear_y7", 0, sym(0, 3, 7, 1, 0, 0)); drive_block(blk, 0); drain();

        // Only q63 nonzero: three ZRLs then a final coefficient with last, no EOB.
        blk = '0; blk[63] = 32'(1 <<< 16);
        model_block(blk, 2);
        chk("q63_len", 64'(exp_q.size()), 64'd5);
        pin("q63_dc", 0, sym(0, 0, 0, 1, 0, 2));
        for (int i = 1; i <= 3; i++) pin("q63_zrl", i, sym(15, 0, 0, 0, 0, 2));
        pin("q63_last", 4, sym(14, 1, 1, 0, 1, 2));
        drive_block(blk, 2);
        drain();

        // Saturation and rounding.
        blk = '0; blk[1] = 32'h7FFF_FFFF; blk[2] = 32'h8000_0000;
        blk[3] = 32'h0001_8000; blk[4] = 32'hFFFE_8000;
        model_block(blk, 2);
        pin("sat_pos",   1, sym(0, 11, 11'h7FF, 0, 0, 2));
        pin("sat_neg",   2, sym(0, 11, 0, 0, 0, 2));
        pin("round_up",  3, sym(0, 2, 2, 0, 0, 2));
        pin("round_neg", 4, sym(0, 1, 0, 0, 0, 2));
        pin("sat_eob",   5, sym(0, 0, 0, 0, 1, 2));
        drive_block(blk, 2);
        drain();

        // Random blocks under random backpressure.
        stall_mode = 1'b1;
        for (int b = 0; b < 100; b++) begin
            if ($urandom_range(0, 9) == 0) pulse_clear();
            blk = '0;
            blk[0] = 32'(((int'($urandom_range(0, 6000)) - 3000) <<< 16) + int'($urandom_range(0, 65535)));
            for (int i = 1; i < 64; i++) begin
                r = $urandom_range(0, 99);
                if (r < 12) begin
                    m = int'($urandom_range(0, 80)) - 40;
                    blk[i] = 32'((m <<< 16) + int'($urandom_range(0, 65535)));
                end else if (r < 14) begin
                    blk[i] = $urandom();
                end
            end
            send_block(blk, $urandom_range(0, 3));
        end
        drain();
        stall_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
